// File: rtl/branch_predict_resolve_unit.sv
// branch_predict_resolve_unit: 2-bit BHT branch predictor with a one-cycle registered
// branch/jump resolver, redirect PC generation and a saturating mispredict counter.
module branch_predict_resolve_unit #(
    parameter int         XLEN        = 32,
    parameter int         BHT_ENTRIES = 64,
    parameter logic [1:0] CTR_INIT    = 2'b01,
    parameter int         CNT_W       = 16
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [XLEN-1:0]  pred_pc_in,
    output logic             pred_taken_out,
    input  logic             res_valid_in,
    input  logic [XLEN-1:0]  res_pc_in,
    input  logic [4:0]       opcode_6_to_2_in,
    input  logic [2:0]       func3_in,
    input  logic [XLEN-1:0]  rs1_in,
    input  logic [XLEN-1:0]  rs2_in,
    input  logic [XLEN-1:0]  target_in,
    input  logic             pred_taken_in,
    output logic             res_valid_out,
    output logic             branch_taken_out,
    output logic             mispredict_out,
    output logic [XLEN-1:0]  redirect_pc_out,
    output logic [CNT_W-1:0] mispredict_count_out
);
    localparam int         IDX_W   = $clog2(BHT_ENTRIES);
    localparam logic [4:0] OP_BR   = 5'b11000;
    localparam logic [4:0] OP_JAL  = 5'b11011;
    localparam logic [4:0] OP_JALR = 5'b11001;

    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [IDX_W-1:0] pred_idx, res_idx;
    logic             res_valid_q, taken_q, mis_q;
    logic [XLEN-1:0]  redirect_q;
    logic [CNT_W-1:0] count_q;
    logic             is_br, eq, lt_s, lt_u, cond, taken_d, mis_d;
    logic [1:0]       ctr_q, ctr_d;
    logic [XLEN-1:0]  redirect_d;
    logic             unused_pred_pc;

    assign pred_idx       = pred_pc_in[IDX_W+1:2];
    assign res_idx        = res_pc_in[IDX_W+1:2];
    assign unused_pred_pc = ^{pred_pc_in[XLEN-1:IDX_W+2], pred_pc_in[1:0]};
    // Plain array read: a same-cycle update at this index is seen only next cycle.
    assign pred_taken_out = bht_q[pred_idx][1];

    always_comb begin
        eq    = rs1_in == rs2_in;
        lt_s  = $signed(rs1_in) < $signed(rs2_in);
        lt_u  = rs1_in < rs2_in;
        cond  = 1'b0;
        case (func3_in)
            3'b000:  cond = eq;
            3'b001:  cond = !eq;
            3'b100:  cond = lt_s;
            3'b101:  cond = !lt_s;
            3'b110:  cond = lt_u;
            3'b111:  cond = !lt_u;
            default: cond = 1'b0;
        endcase
        is_br      = opcode_6_to_2_in == OP_BR;
        taken_d    = (opcode_6_to_2_in == OP_JAL) || (opcode_6_to_2_in == OP_JALR) || (is_br && cond);
        mis_d      = taken_d != pred_taken_in;
        redirect_d = taken_d ? target_in : res_pc_in + XLEN'(4);
        ctr_q      = bht_q[res_idx];
        ctr_d      = taken_d ? ((ctr_q == 2'd3) ? 2'd3 : ctr_q + 2'd1)
                             : ((ctr_q == 2'd0) ? 2'd0 : ctr_q - 2'd1);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CTR_INIT;
            res_valid_q <= 1'b0;
            taken_q     <= 1'b0;
            mis_q       <= 1'b0;
            redirect_q  <= '0;
            count_q     <= '0;
        end else begin
            res_valid_q <= res_valid_in;
            if (res_valid_in) begin
                taken_q    <= taken_d;
                mis_q      <= mis_d;
                redirect_q <= redirect_d;
                if (mis_d && (count_q != '1)) count_q <= count_q + CNT_W'(1);
                if (is_br) bht_q[res_idx] <= ctr_d;
            end
        end
    end

    assign res_valid_out        = res_valid_q;
    assign branch_taken_out     = taken_q;
    assign mispredict_out       = mis_q;
    assign redirect_pc_out      = redirect_q;
    assign mispredict_count_out = count_q;
endmodule

// File: tb/tb_branch_predict_resolve_unit.sv
// tb_branch_predict_resolve_unit: scoreboard bench with a reference BHT and counter model;
// small CNT_W keeps the mispredict-counter saturation run short.
module tb_branch_predict_resolve_unit;
    localparam int XLEN = 32;
    localparam int N    = 64;
    localparam int CW   = 4;

    logic            clk_in = 1'b0;
    logic            rst_n_in;
    logic [XLEN-1:0] pred_pc_in;
    logic            pred_taken_out;
    logic            res_valid_in;
    logic [XLEN-1:0] res_pc_in;
    logic [4:0]      opcode_6_to_2_in;
    logic [2:0]      func3_in;
    logic [XLEN-1:0] rs1_in, rs2_in, target_in;
    logic            pred_taken_in;
    logic            res_valid_out, branch_taken_out, mispredict_out;
    logic [XLEN-1:0] redirect_pc_out;
    logic [CW-1:0]   mispredict_count_out;

    branch_predict_resolve_unit #(.XLEN(XLEN), .BHT_ENTRIES(N), .CTR_INIT(2'b01), .CNT_W(CW)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .pred_pc_in(pred_pc_in), .pred_taken_out(pred_taken_out),
        .res_valid_in(res_valid_in), .res_pc_in(res_pc_in), .opcode_6_to_2_in(opcode_6_to_2_in),
        .func3_in(func3_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .target_in(target_in),
        .pred_taken_in(pred_taken_in), .res_valid_out(res_valid_out), .branch_taken_out(branch_taken_out),
        .mispredict_out(mispredict_out), .redirect_pc_out(redirect_pc_out),
        .mispredict_count_out(mispredict_count_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic        taken;
        logic        mis;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   total = 0;
    int   bad   = 0;
    int   ref_bht [N];
    int   ref_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic model_taken(input logic [4:0] op, input logic [2:0] f3,
                                         input logic [31:0] a, input logic [31:0] b);
        if (op == 5'b11011 || op == 5'b11001) return 1'b1;
        if (op != 5'b11000) return 1'b0;
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) ref_bht[i] = 1;
        ref_cnt = 0;
    endtask

    task automatic pred_chk(input string tag, input logic [31:0] pc);
        pred_pc_in = pc;
        #1;
        check(tag, pred_taken_out, ref_bht[pc[7:2]] >= 2);
    endtask

    task automatic resolve(input logic [4:0] op, input logic [2:0] f3, input logic [31:0] pc,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] tgt,
                           input logic pt);
        exp_t e;
        int   idx;
        res_valid_in = 1'b1; opcode_6_to_2_in = op; func3_in = f3; res_pc_in = pc;
        rs1_in = a; rs2_in = b; target_in = tgt; pred_taken_in = pt; pred_pc_in = pc;
        idx = int'(pc[7:2]);
        #1;
        check("pred_pre_update", pred_taken_out, ref_bht[idx] >= 2);
        e.taken = model_taken(op, f3, a, b);
        e.mis   = e.taken != pt;
        e.rd    = e.taken ? tgt : pc + 32'd4;
        sb.push_back(e);
        if (op == 5'b11000) ref_bht[idx] = e.taken ? (ref_bht[idx] == 3 ? 3 : ref_bht[idx] + 1)
                                                   : (ref_bht[idx] == 0 ? 0 : ref_bht[idx] - 1);
        if (e.mis && ref_cnt < (1 << CW) - 1) ref_cnt++;
        @(posedge clk_in);
        #1;
        res_valid_in = 1'b0;
        e = sb.pop_front();
        check("res_valid", res_valid_out, 1);
        check("taken", branch_taken_out, e.taken);
        check("mispredict", mispredict_out, e.mis);
        check("redirect", redirect_pc_out, e.rd);
        check("mis_count", mispredict_count_out, ref_cnt);
        last_exp = e;
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        res_valid_in = 1'b1; opcode_6_to_2_in = 5'b11000; func3_in = 3'd0; res_pc_in = 32'h100;
        rs1_in = 32'd5; rs2_in = 32'd5; target_in = 32'h200; pred_taken_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        res_valid_in = 1'b0;
        model_reset();
        check("rst_valid", res_valid_out, 0);
        check("rst_taken", branch_taken_out, 0);
        check("rst_mis", mispredict_out, 0);
        check("rst_redirect", redirect_pc_out, 0);
        check("rst_count", mispredict_count_out, 0);
        pred_chk("rst_pred_100", 32'h100);
        @(posedge clk_in);
        #1;
        check("post_rst_valid", res_valid_out, 0);
        check("post_rst_count", mispredict_count_out, 0);
    endtask

    initial begin
        logic [31:0] vals [4];
        logic [4:0]  ops [5];
        vals[0] = 32'h0; vals[1] = 32'h1; vals[2] = 32'hFFFF_FFFF; vals[3] = 32'h8000_0000;
        ops[0] = 5'b11000; ops[1] = 5'b11000; ops[2] = 5'b11011; ops[3] = 5'b11001; ops[4] = 5'b01100;
        pred_pc_in = 32'h0;
        model_reset();
        do_reset();
        pred_chk("rst_pred_0", 32'h0);
        pred_chk("rst_pred_fc", 32'hFC);

        resolve(5'b11000, 3'd0, 32'h100, 32'd5, 32'd5, 32'h200, 1'b0);
        resolve(5'b11000, 3'd0, 32'h100, 32'd5, 32'd5, 32'h200, 1'b0);
        pred_pc_in = 32'h100;
        #1;
        check("beq_trained_pred", pred_taken_out, 1);
        check("beq_count", mispredict_count_out, 2);

        resolve(5'b11000, 3'd4, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h400, 1'b0);
        resolve(5'b11000, 3'd6, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h400, 1'b0);

        resolve(5'b11001, 3'd0, 32'h40, 32'd0, 32'd0, 32'h800, 1'b1);
        pred_chk("jalr_no_update", 32'h40);

        res_valid_in = 1'b0;
        @(posedge clk_in);
        #1;
        check("idle_valid", res_valid_out, 0);
        check("idle_taken_hold", branch_taken_out, last_exp.taken);
        check("idle_redirect_hold", redirect_pc_out, last_exp.rd);

        repeat (3) resolve(5'b11000, 3'd1, 32'hFFFF_FFFC, 32'd7, 32'd7, 32'h10, 1'b0);
        resolve(5'b11000, 3'd0, 32'hFFFF_FFFC, 32'd7, 32'd7, 32'h10, 1'b0);
        pred_chk("sat_low_pred", 32'hFFFF_FFFC);
        resolve(5'b11000, 3'd2, 32'h500, 32'd1, 32'd1, 32'h20, 1'b1);

        for (int k = 0; k < 80; k++) begin
            logic [31:0] pc;
            pc = 32'h1000 + ({27'd0, 5'($urandom_range(0, 7))} << 2);
            resolve(ops[$urandom_range(0, 4)], 3'($urandom_range(0, 7)), pc,
                    vals[$urandom_range(0, 3)], vals[$urandom_range(0, 3)], $urandom & 32'hFFFF_FFFC,
                    1'($urandom_range(0, 1)));
        end

        repeat (20) resolve(5'b11011, 3'd0, 32'h600, 32'd0, 32'd0, 32'h700, 1'b0);
        check("count_saturated", mispredict_count_out, 4'hF);

        do_reset();
        pred_chk("rst_table_init", 32'h1000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_predict_resolve_unit.md
BRANCH_PREDICT_RESOLVE_UNIT -- requirements
Module: branch_predict_resolve_unit

Interface
REQ-001 Parameter XLEN, default 32, operand, PC and target width in bits.
REQ-002 Parameter BHT_ENTRIES, default 64, number of branch history table entries; power of two, 4..1024.
REQ-003 Parameter CTR_INIT, default 2'b01, reset value of every 2-bit history counter.
REQ-004 Parameter CNT_W, default 16, mispredict counter width.
REQ-005 clk_in  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n_in  input  1  reset, synchronous, active-low.
REQ-007 pred_pc_in  input  XLEN  fetch-stage PC to predict.
REQ-008 pred_taken_out  output  1  combinational prediction for pred_pc_in.
REQ-009 res_valid_in  input  1  resolve request valid this cycle.
REQ-010 res_pc_in  input  XLEN  PC of the instruction being resolved.
REQ-011 opcode_6_to_2_in  input  5  instruction opcode bits 6:2.
REQ-012 func3_in  input  3  instruction func3.
REQ-013 rs1_in, rs2_in  input  XLEN each  source operands.
REQ-014 target_in  input  XLEN  computed branch/jump target.
REQ-015 pred_taken_in  input  1  prediction made at fetch for this instruction.
REQ-016 res_valid_out  output  1  registered outputs below are valid.
REQ-017 branch_taken_out  output  1  resolved taken decision.
REQ-018 mispredict_out  output  1  resolved decision differs from pred_taken_in.
REQ-019 redirect_pc_out  output  XLEN  correct next PC.
REQ-020 mispredict_count_out  output  CNT_W  saturating count of mispredicts.

Function
REQ-021 Table index SHALL be PC[log2(BHT_ENTRIES)+1:2] for both prediction and update.
REQ-022 pred_taken_out SHALL equal bit 1 of the indexed counter (values 2,3 = taken); read is combinational, no write bypass.
REQ-023 Taken decision: opcode 11011 (JAL) or 11001 (JALR) -> 1; opcode 11000 -> func3 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE, 010/011 -> 0; any other opcode -> 0.
REQ-024 Comparisons SHALL use full XLEN width, signed two's complement for 100/101, unsigned for 110/111.
REQ-025 Outputs res_valid_out, branch_taken_out, mispredict_out, redirect_pc_out SHALL be registered: latency exactly 1 cycle from res_valid_in sampled high.
REQ-026 redirect_pc_out SHALL be target_in if taken, else res_pc_in + 4 (modulo 2^XLEN, wrap at all-ones).
REQ-027 When res_valid_in is low, res_valid_out SHALL be 0 next cycle, and other registered outputs SHALL hold their previous values.
REQ-028 Counter update SHALL occur only when res_valid_in=1 and opcode=11000 (any func3): taken -> increment saturating at 3; not taken -> decrement saturating at 0.
REQ-029 JAL, JALR and non-branch opcodes SHALL NOT modify the table.
REQ-030 Func3 010/011 with opcode 11000 SHALL decrement the counter (treated as not taken).
REQ-031 mispredict_count_out SHALL increment by 1 on each cycle res_valid_in=1 and taken != pred_taken_in, for every opcode, saturating at all-ones.
REQ-032 Same-cycle prediction and update of the same index: pred_taken_out reflects the pre-update value; new value visible next cycle.
REQ-033 Back-to-back resolves SHALL be accepted every cycle with no stall; two consecutive updates to the same index both take effect.

Reset
REQ-034 On rst_n_in low at a rising edge, all counters SHALL load CTR_INIT; res_valid_out, branch_taken_out, mispredict_out SHALL be 0; redirect_pc_out and mispredict_count_out SHALL be 0.
REQ-035 Reset SHALL take priority over a simultaneous resolve; that resolve is discarded and does not update table or counter.
REQ-036 Reset deasserted mid-sequence SHALL leave no residual output valid in the first post-reset cycle.

Verification
REQ-037 After reset, pred_pc_in=0x100 -> pred_taken_out=0 (CTR_INIT=01); any index reads 0.
REQ-038 Two resolves BEQ, pc=0x100, rs1=rs2=5, pred_taken_in=0, target=0x200 -> cycle+1: taken=1, mispredict=1, redirect=0x200; after both, pred for 0x100 =1, count=2.
REQ-039 BLT rs1=0xFFFFFFFF, rs2=1 -> taken=1; BLTU same operands -> taken=0, redirect=pc+4.
REQ-040 JALR pc=0x40, pred_taken_in=1 -> taken=1, mispredict=0; counter at index of 0x40 unchanged.
REQ-041 Resolve pc=0xFFFFFFFC not-taken BNE rs1=rs2 -> redirect_pc_out=0x00000000; counter saturates at 0 after repeated not-taken.
REQ-042 Force mispredict_count_out to all-ones via 2^CNT_W mispredicts -> further mispredict leaves it all-ones; reset asserted with res_valid_in=1 -> all outputs 0, table at CTR_INIT.
